// File: rtl/valu_seq.sv
// Vector ALU word sequencer: walks n_words operand words through an
// external v_alu (read, operate, optional adder wait, write back).
module valu_seq #(
  parameter int VECTOR_LENGTH = 128,
  parameter int VALU_OP_W_MAX = 32,
  localparam int WORDS = VECTOR_LENGTH / VALU_OP_W_MAX,
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int NW = $clog2(WORDS) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               op_instr,
  input  logic [1:0]               vsew,
  input  logic [NW-1:0]            n_words,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     rd_en,
  output logic [IW-1:0]            rd_idx,
  input  logic [VALU_OP_W_MAX-1:0] rd_a,
  input  logic [VALU_OP_W_MAX-1:0] rd_b,
  output logic [3:0]               alu_op,
  output logic [1:0]               alu_vsew,
  output logic [VALU_OP_W_MAX-1:0] alu_a,
  output logic [VALU_OP_W_MAX-1:0] alu_b,
  input  logic [VALU_OP_W_MAX-1:0] alu_result,
  output logic                     wr_en,
  output logic [IW-1:0]            wr_idx,
  output logic [VALU_OP_W_MAX-1:0] wr_data
);

  localparam logic [3:0] VALU_VADD = 4'd0;
  localparam logic [3:0] VALU_VSUB = 4'd1;
  localparam logic [3:0] VALU_VAND = 4'd2;
  localparam logic [3:0] VALU_VOR  = 4'd3;
  localparam logic [3:0] VALU_VXOR = 4'd4;
  localparam logic [3:0] VALU_VSLL = 4'd5;
  localparam logic [3:0] VALU_VSRL = 4'd6;
  localparam logic [3:0] VALU_VSRA = 4'd7;
  localparam logic [3:0] VALU_VMIN = 4'd8;
  localparam logic [3:0] VALU_VMAX = 4'd9;

  localparam logic [1:0] VSEW_8  = 2'd0;
  localparam logic [1:0] VSEW_16 = 2'd1;
  localparam logic [1:0] VSEW_32 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_OP,
    S_WAIT,
    S_WB,
    S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 op_q, op_d;
  logic [1:0]                 sew_q, sew_d;
  logic [NW-1:0]              n_q, n_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic                       ill_q, ill_d;
  logic [VALU_OP_W_MAX-1:0]   a_q, a_d;
  logic [VALU_OP_W_MAX-1:0]   b_q, b_d;

  logic cmd_ill;
  logic is_add;
  logic last_word;

  always_comb begin
    cmd_ill = 1'b0;
    if (!(op_instr inside {VALU_VADD, VALU_VSUB, VALU_VAND,
                           VALU_VOR, VALU_VXOR, VALU_VSLL,
                           VALU_VSRL, VALU_VSRA, VALU_VMIN,
                           VALU_VMAX}))
      cmd_ill = 1'b1;
    if (!(vsew inside {VSEW_8, VSEW_16, VSEW_32}))
      cmd_ill = 1'b1;
    if (n_words > NW'(WORDS))
      cmd_ill = 1'b1;
  end

  // Add/sub go through a registered adder and need one extra cycle.
  assign is_add = (op_q == VALU_VADD) || (op_q == VALU_VSUB);
  assign last_word = (NW'(idx_q) == (n_q - NW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sew_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      ill_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sew_q   <= sew_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      ill_q   <= ill_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sew_d   = sew_q;
    n_d     = n_q;
    idx_d   = idx_q;
    ill_d   = ill_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op_instr;
          sew_d = vsew;
          n_d   = n_words;
          idx_d = '0;
          ill_d = cmd_ill;
          if (cmd_ill || (n_words == '0))
            state_d = S_DONE;
          else
            state_d = S_RD;
        end
      end
      S_RD: begin
        rd_en   = 1'b1;
        state_d = S_OP;
      end
      S_OP: begin
        a_d     = rd_a;
        b_d     = rd_b;
        state_d = is_add ? S_WAIT : S_WB;
      end
      S_WAIT: begin
        state_d = S_WB;
      end
      S_WB: begin
        wr_en = 1'b1;
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_RD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        err     = ill_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign rd_idx   = idx_q;
  assign wr_idx   = idx_q;
  assign wr_data  = alu_result;
  assign alu_op   = op_q;
  assign alu_vsew = sew_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;

endmodule

// File: tb/tb_valu_seq.sv
// Bench for valu_seq: stand-in register file and v_alu, a per-cycle
// schedule model, and directed commands with literal expectations.
module tb_valu_seq;

  localparam logic [3:0] VALU_VADD = 4'd0;
  localparam logic [3:0] VALU_VSUB = 4'd1;
  localparam logic [3:0] VALU_VAND = 4'd2;
  localparam logic [3:0] VALU_VOR  = 4'd3;
  localparam logic [3:0] VALU_VXOR = 4'd4;
  localparam logic [3:0] VALU_VSLL = 4'd5;
  localparam logic [3:0] VALU_VSRL = 4'd6;
  localparam logic [3:0] VALU_VSRA = 4'd7;
  localparam logic [3:0] VALU_VMIN = 4'd8;
  localparam logic [3:0] VALU_VMAX = 4'd9;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op_instr = '0;
  logic [1:0]  vsew = '0;
  logic [2:0]  n_words = '0;
  logic        busy, done, err, rd_en, wr_en;
  logic [1:0]  rd_idx, wr_idx;
  logic [31:0] rd_a = '0, rd_b = '0;
  logic [3:0]  alu_op;
  logic [1:0]  alu_vsew;
  logic [31:0] alu_a, alu_b, alu_result, wr_data;
  logic [31:0] add_q = '0;

  logic [31:0] A [WORDS];
  logic [31:0] B [WORDS];
  logic [31:0] wlog [$];

  int errors = 0;
  int checks = 0;
  int wcommit = 0;

  valu_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .op_instr(op_instr), .vsew(vsew), .n_words(n_words),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_a(rd_a), .rd_b(rd_b),
    .alu_op(alu_op), .alu_vsew(alu_vsew),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op,
      input logic [1:0] sew, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] m, ea, eb, x;
    longint sa, sb;
    int ew, sh;
    r = '0;
    ew = (sew == 2'd0) ? 8 : (sew == 2'd1) ? 16 : 32;
    m = (64'd1 << ew) - 64'd1;
    for (int l = 0; l < 32 / ew; l++) begin
      ea = ({32'd0, a} >> (l * ew)) & m;
      eb = ({32'd0, b} >> (l * ew)) & m;
      sa = longint'(ea);
      sb = longint'(eb);
      if (ea[ew-1]) sa = sa - longint'(64'd1 << ew);
      if (eb[ew-1]) sb = sb - longint'(64'd1 << ew);
      sh = int'(eb % 64'(ew));
      case (op)
        VALU_VADD: x = ea + eb;
        VALU_VSUB: x = ea - eb;
        VALU_VAND: x = ea & eb;
        VALU_VOR:  x = ea | eb;
        VALU_VXOR: x = ea ^ eb;
        VALU_VSLL: x = ea << sh;
        VALU_VSRL: x = ea >> sh;
        VALU_VSRA: x = 64'(sa >>> sh);
        VALU_VMIN: x = (sa < sb) ? ea : eb;
        VALU_VMAX: x = (sa > sb) ? ea : eb;
        default:   x = '0;
      endcase
      r = r | 32'((x & m) << (l * ew));
    end
    return r;
  endfunction

  // Register file returns data one cycle after the read request.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_a <= A[rd_idx];
      rd_b <= B[rd_idx];
    end
    add_q <= alu_f(alu_op, alu_vsew, alu_a, alu_b);
    if (wr_en) wcommit <= wcommit + 1;
  end

  always_comb begin
    if (alu_op == VALU_VADD || alu_op == VALU_VSUB)
      alu_result = add_q;
    else
      alu_result = alu_f(alu_op, alu_vsew, alu_a, alu_b);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Schedule model: m_t is the cycle number since the accepted start.
  bit         m_act = 1'b0;
  int         m_t = 0;
  int         m_T = 0;
  int         m_p = 3;
  bit         m_ill = 1'b0;
  logic [3:0] m_op = '0;
  logic [1:0] m_sew = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0;
      m_t = 0;
    end else if (m_act) begin
      if (m_t >= m_T) m_act = 1'b0;
      else m_t++;
    end else if (start) begin
      m_act = 1'b1;
      m_t = 1;
      m_op = op_instr;
      m_sew = vsew;
      m_ill = (op_instr > VALU_VMAX) || (vsew == 2'd3)
              || (int'(n_words) > WORDS);
      m_p = (op_instr == VALU_VADD || op_instr == VALU_VSUB) ? 4 : 3;
      m_T = (m_ill || n_words == 0) ? 1 : m_p * int'(n_words) + 1;
    end
  end

  always @(negedge clk) begin
    bit e_rd, e_wr, e_done;
    int w;
    e_rd = 1'b0;
    e_wr = 1'b0;
    w = 0;
    e_done = m_act && (m_t == m_T);
    if (m_act && m_t < m_T) begin
      w = (m_t - 1) / m_p;
      e_rd = ((m_t - 1) % m_p) == 0;
      e_wr = ((m_t - 1) % m_p) == m_p - 1;
    end
    chk("busy", 32'(busy), 32'(m_act));
    chk("done", 32'(done), 32'(e_done));
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    if (e_done) chk("err", 32'(err), 32'(m_ill));
    if (m_act) begin
      chk("alu_op", 32'(alu_op), 32'(m_op));
      chk("alu_vsew", 32'(alu_vsew), 32'(m_sew));
    end
    if (e_rd) chk("rd_idx", 32'(rd_idx), 32'(w));
    if (e_wr) begin
      chk("wr_idx", 32'(wr_idx), 32'(w));
      chk("alu_a", alu_a, A[w]);
      chk("alu_b", alu_b, B[w]);
      chk("wr_data", wr_data, alu_f(m_op, m_sew, A[w], B[w]));
    end
  end

  task automatic run_cmd(input logic [3:0] op, input logic [1:0] sew,
      input logic [2:0] n, output int dcyc, output logic derr,
      output int nacc);
    wlog.delete();
    @(negedge clk);
    #1;
    op_instr = op;
    vsew = sew;
    n_words = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dcyc = -1;
    derr = 1'b0;
    nacc = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (rd_en) nacc++;
      if (wr_en) begin
        nacc++;
        wlog.push_back(wr_data);
      end
      if (done) begin
        dcyc = c;
        derr = err;
        break;
      end
    end
    if (dcyc < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done for op %0d", op);
    end
  endtask

  initial begin
    int d, d1, d2, na, nw, base, nd;
    logic e;
    for (int i = 0; i < WORDS; i++) begin
      A[i] = '0;
      B[i] = '0;
    end
    #3;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst err", 32'(err), 0);
    chk("rst rd_en", 32'(rd_en), 0);
    chk("rst wr_en", 32'(wr_en), 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_b", alu_b, 0);
    chk("rst alu_op", 32'(alu_op), 0);
    chk("rst alu_vsew", 32'(alu_vsew), 0);
    @(negedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < WORDS; i++) begin
      A[i] = 32'hFFFF0000 + i;
      B[i] = 32'h0F0F0F0F;
    end
    run_cmd(VALU_VAND, 2'd2, 3'd4, d, e, na);
    chk("vand done cyc", d, 13);
    chk("vand err", 32'(e), 0);
    chk("vand writes", wlog.size(), 4);
    for (int i = 0; i < wlog.size(); i++)
      chk("vand data", wlog[i], 32'h0F0F0000 + i);

    A[0] = 32'h7F01FF10; B[0] = 32'h01010120;
    A[1] = 32'h7F01FF10; B[1] = 32'h01010120;
    run_cmd(VALU_VADD, 2'd0, 3'd2, d, e, na);
    chk("vadd done cyc", d, 9);
    chk("vadd writes", wlog.size(), 2);
    for (int i = 0; i < wlog.size(); i++)
      chk("vadd data", wlog[i], 32'h80020030);

    run_cmd(VALU_VOR, 2'd2, 3'd0, d, e, na);
    chk("n0 done cyc", d, 1);
    chk("n0 err", 32'(e), 0);
    chk("n0 accesses", na, 0);

    run_cmd(4'hF, 2'd2, 3'd2, d, e, na);
    chk("badop done cyc", d, 1);
    chk("badop err", 32'(e), 1);
    chk("badop accesses", na, 0);

    run_cmd(VALU_VAND, 2'd2, 3'd5, d, e, na);
    chk("n5 done cyc", d, 1);
    chk("n5 err", 32'(e), 1);
    chk("n5 accesses", na, 0);

    run_cmd(VALU_VAND, 2'd3, 3'd1, d, e, na);
    chk("badsew err", 32'(e), 1);
    chk("badsew accesses", na, 0);

    A[0] = 32'h80007FF0; B[0] = 32'h00040001;
    for (int i = 1; i < WORDS; i++) begin
      A[i] = $urandom;
      B[i] = $urandom;
    end
    run_cmd(VALU_VSRA, 2'd1, 3'd3, d, e, na);
    chk("vsra done cyc", d, 10);
    if (wlog.size() > 0) chk("vsra data0", wlog[0], 32'hF8003FF8);

    for (int i = 0; i < WORDS; i++) begin
      A[i] = $urandom;
      B[i] = $urandom;
    end
    run_cmd(VALU_VMIN, 2'd0, 3'd4, d, e, na);
    chk("vmin done cyc", d, 13);
    run_cmd(VALU_VSLL, 2'd1, 3'd2, d, e, na);
    chk("vsll done cyc", d, 7);
    run_cmd(VALU_VMAX, 2'd2, 3'd3, d, e, na);
    chk("vmax done cyc", d, 10);

    // Abort a VSUB during its third write-back.
    base = wcommit;
    @(negedge clk);
    #1;
    op_instr = VALU_VSUB;
    vsew = 2'd1;
    n_words = 3'd4;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nw = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (wr_en) nw++;
      if (nw == 3) break;
    end
    chk("abort reached wb3", nw, 3);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 0);
    chk("abort wr_en", 32'(wr_en), 0);
    chk("abort alu_a", alu_a, 0);
    #1 rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort commits", wcommit - base, 2);
    chk("abort no done", nd, 0);

    run_cmd(VALU_VXOR, 2'd2, 3'd1, d, e, na);
    chk("vxor done cyc", d, 4);
    chk("vxor err", 32'(e), 0);

    // Start held high; op input changes while busy.
    @(negedge clk);
    #1;
    op_instr = VALU_VOR;
    vsew = 2'd2;
    n_words = 3'd1;
    start = 1'b1;
    @(posedge clk);
    #1 op_instr = VALU_VAND;
    d1 = -1;
    d2 = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 2) chk("held alu_op 1st", 32'(alu_op), 32'(VALU_VOR));
      if (c == 7) chk("held alu_op 2nd", 32'(alu_op), 32'(VALU_VAND));
      if (done) begin
        if (d1 < 0) begin
          d1 = c;
        end else begin
          d2 = c;
          #1 start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    chk("held done 1st", d1, 4);
    chk("held done 2nd", d2, 9);
    repeat (3) @(negedge clk);
    chk("held idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/valu_seq.md
VALU_SEQ -- requirements
Module: valu_seq

Interface
- REQ-001: Parameter VECTOR_LENGTH, default 128, bits per vector register.
- REQ-002: Parameter VALU_OP_W_MAX, default 32, VALU operand width; WORDS = VECTOR_LENGTH/VALU_OP_W_MAX (default 4).
- REQ-003: Reset polarity is fixed: one clock; reset is asynchronous and active-high.
- REQ-004: clk  in  1  single clock, rising-edge.
- REQ-005: rst  in  1  asynchronous, active-high reset.
- REQ-006: start  in  1  command request, sampled only in IDLE.
- REQ-007: op_instr  in  4  v_pkg VALU opcode.
- REQ-008: vsew  in  2  element width (VSEW_8/16/32).
- REQ-009: n_words  in  $clog2(WORDS)+1  number of 32-bit words to process, 0..WORDS.
- REQ-010: busy  out  1  high in every state except IDLE.
- REQ-011: done  out  1  one-cycle completion pulse.
- REQ-012: err  out  1  valid with done; 1 means illegal command.
- REQ-013: rd_en / rd_idx  out  1 / $clog2(WORDS)  operand word read request; register file returns data next cycle.
- REQ-014: rd_a, rd_b  in  VALU_OP_W_MAX  operand words, valid the cycle after rd_en.
- REQ-015: alu_op / alu_vsew  out  4 / 2  latched command to v_alu.
- REQ-016: alu_a, alu_b  out  VALU_OP_W_MAX  registered operands to v_alu.
- REQ-017: alu_result  in  VALU_OP_W_MAX  v_alu result.
- REQ-018: wr_en / wr_idx / wr_data  out  1 / $clog2(WORDS) / VALU_OP_W_MAX  result write-back.

Function
- REQ-019: FSM states: IDLE, RD, OP, WAIT, WB, DONE.
- REQ-020: IDLE with start=1: latch op_instr, vsew, n_words; clear word index to 0; next state is DONE if the op is illegal or n_words=0, else RD.
- REQ-021: Legal ops: VALU_VADD, VALU_VSUB, VALU_VAND, VALU_VOR, VALU_VXOR, VALU_VSLL, VALU_VSRL, VALU_VSRA, VALU_VMIN, VALU_VMAX; any other encoding, vsew not in {VSEW_8, VSEW_16, VSEW_32}, or n_words>WORDS is illegal.
- REQ-022: RD: rd_en=1, rd_idx=word index; next state OP.
- REQ-023: OP: register rd_a/rd_b into alu_a/alu_b at the end of the cycle; next state WAIT for VADD/VSUB (registered adder), else WB.
- REQ-024: WAIT: operands held; single cycle; next state WB.
- REQ-025: WB: wr_en=1, wr_idx=word index, wr_data=alu_result (combinational pass-through); if index=n_words-1 next state DONE, else increment index and go to RD.
- REQ-026: DONE: done=1 for exactly one cycle; err=1 iff the command was illegal; next state IDLE.
- REQ-027: Latency from the start cycle (cycle 0) to the done cycle: 3n+1 cycles for single-cycle ops, 4n+1 for VADD/VSUB, 1 for n=0 or an illegal command.
- REQ-028: alu_op/alu_vsew hold the latched values from start through DONE; they are unaffected by input changes while busy.
- REQ-029: start while busy is ignored, with no queuing.
- REQ-030: Illegal command or n_words=0: no rd_en or wr_en pulse is issued.
- REQ-031: At most one of rd_en and wr_en is high in any cycle; write indices are strictly ascending 0..n-1 with no repeats.

Reset
- REQ-032: rst=1 forces IDLE immediately, independent of clk; busy, done, err, rd_en, wr_en, word index, alu_a, and alu_b are all 0, and alu_op/alu_vsew are 0.
- REQ-033: Reset mid-command aborts it: no done pulse and no further writes; the first rising edge after rst deasserts sees IDLE.

Verification
- REQ-034: VAND, VSEW_32, n=4, rd_a=0xFFFF0000+idx, rd_b=0x0F0F0F0F -> 4 writes, idx 0..3, data 0x0F0F0000+(idx&0x0F0F0F0F), done at cycle 13, err=0.
- REQ-035: VADD, VSEW_8, n=2, a=0x7F01FF10, b=0x01010120 (bench model of a 1-cycle-registered adder) -> wr_data 0x80020030 per word, done at cycle 9.
- REQ-036: n_words=0 and op=VALU_VOR -> done at cycle 1, err=0, no rd_en or wr_en.
- REQ-037: Undefined opcode, and separately n_words=5 -> done at cycle 1 with err=1, no accesses.
- REQ-038: VSUB, n=4, rst pulsed during the third WB -> busy=0 asynchronously, only 2 writes observed, no done; a following VXOR, n=1 completes normally at cycle 4.
- REQ-039: start held high continuously for VOR, n=1 -> second command begins only after DONE→IDLE; the op change on the inputs during busy has no effect on alu_op.
